// File: rtl/add_sub_pkg.sv
// -----------------------------------------------------------------------------
// add_sub_pkg
// Shared definitions for the add/subtract sequencer:
//   - state_t : scheduler FSM state encoding
//   - N_DEF   : default operand MSB index (operand width N_DEF+1)
//   - TMO_DEF : default WAIT-state timeout in cycles
// -----------------------------------------------------------------------------
package add_sub_pkg;

    localparam int N_DEF   = 3;
    localparam int TMO_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/add_sub_sched_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter, purely combinational.
//   req0, req1 : request levels
//   last_gnt   : index of the requester granted most recently
//   winner     : selected requester index (valid only when valid=1)
//   valid      : at least one request present
// Under contention the requester that was not granted last wins.
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic winner,
    output logic valid
);

    // Winner selection: alternate on contention, otherwise pick the lone requester.
    always_comb begin
        winner = 1'b0;
        valid  = req0 | req1;
        if (req0 && req1) begin
            winner = ~last_gnt;
        end else if (req1) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
    end

endmodule

// File: rtl/add_sub_sched.sv
// -----------------------------------------------------------------------------
// add_sub_sched
// Sequencer in front of the add/subtract datapath. Arbitrates two requesters
// round-robin, latches the winner's operands onto dp_*, pulses dp_start, waits
// for dp_flag_end (bounded by TMO cycles) and holds the result for the
// seven-segment path.
// Ports:
//   CLK_in, rst                  : clock (rising edge), async active-low reset
//   req*/a*/b*/cin*/add_min*/symbol* : per-requester request and operands
//   gnt0/gnt1, done0/done1       : one-cycle grant / completion pulses
//   dp_a, dp_b, dp_cin, dp_add_min, dp_symbol, dp_start : datapath drive
//   dp_res, dp_cout, dp_overflow, dp_flag_end            : datapath return
//   res, res_cout, res_ovf, res_err, res_src             : held result
//   busy                         : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module add_sub_sched
    import add_sub_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int TMO = TMO_DEF
) (
    input  logic         CLK_in,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [N:0]   a0,
    input  logic [N:0]   b0,
    input  logic [N:0]   a1,
    input  logic [N:0]   b1,
    input  logic         cin0,
    input  logic         cin1,
    input  logic         add_min0,
    input  logic         add_min1,
    input  logic         symbol0,
    input  logic         symbol1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [N:0]   dp_a,
    output logic [N:0]   dp_b,
    output logic         dp_cin,
    output logic         dp_add_min,
    output logic         dp_symbol,
    output logic         dp_start,
    input  logic [N:0]   dp_res,
    input  logic         dp_cout,
    input  logic         dp_overflow,
    input  logic         dp_flag_end,
    output logic [N:0]   res,
    output logic         res_cout,
    output logic         res_ovf,
    output logic         res_err,
    output logic         res_src,
    output logic         busy
);

    // Timeout fires on the TMO-th WAIT edge without a flag, i.e. when the
    // counter (cleared in ISSUE) still holds TMO-1 at that edge.
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t     state_r;
    logic [7:0] cnt_r;
    logic       win_r;
    logic       last_gnt_r;
    logic       arb_win_s;
    logic       arb_valid_s;

    rr_arb2 u_arb (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt_r),
        .winner   (arb_win_s),
        .valid    (arb_valid_s)
    );

    // Scheduler FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge CLK_in or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            win_r      <= 1'b0;
            last_gnt_r <= 1'b1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            dp_a       <= '0;
            dp_b       <= '0;
            dp_cin     <= 1'b0;
            dp_add_min <= 1'b0;
            dp_symbol  <= 1'b0;
            dp_start   <= 1'b0;
            res        <= '0;
            res_cout   <= 1'b0;
            res_ovf    <= 1'b0;
            res_err    <= 1'b0;
            res_src    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            dp_start <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (arb_valid_s) begin
                        dp_a       <= arb_win_s ? a1 : a0;
                        dp_b       <= arb_win_s ? b1 : b0;
                        dp_cin     <= arb_win_s ? cin1 : cin0;
                        dp_add_min <= arb_win_s ? add_min1 : add_min0;
                        dp_symbol  <= arb_win_s ? symbol1 : symbol0;
                        win_r      <= arb_win_s;
                        last_gnt_r <= arb_win_s;
                        gnt0       <= ~arb_win_s;
                        gnt1       <= arb_win_s;
                        dp_start   <= 1'b1;
                        busy       <= 1'b1;
                        state_r    <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    cnt_r   <= 8'd0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // flag_end is checked first so a coincident timeout still captures.
                    if (dp_flag_end) begin
                        res      <= dp_res;
                        res_cout <= dp_cout;
                        res_ovf  <= dp_overflow;
                        res_err  <= 1'b0;
                        res_src  <= win_r;
                        done0    <= ~win_r;
                        done1    <= win_r;
                        state_r  <= ST_DONE;
                    end else if (cnt_r == TMO_LAST) begin
                        res      <= '0;
                        res_cout <= 1'b0;
                        res_ovf  <= 1'b0;
                        res_err  <= 1'b1;
                        res_src  <= win_r;
                        done0    <= ~win_r;
                        done1    <= win_r;
                        state_r  <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_sub_sched.sv
// -----------------------------------------------------------------------------
// tb_add_sub_sched
// Self-checking bench for add_sub_sched. A datapath stub answers dp_start
// after a programmable number of WAIT cycles; expected results come from an
// integer-arithmetic model of the granted requester's operands and a
// round-robin model of the arbitration order.
// -----------------------------------------------------------------------------
module tb_add_sub_sched;

    logic       CLK_in = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] a0 = 4'd0, b0 = 4'd0, a1 = 4'd0, b1 = 4'd0;
    logic       cin0 = 1'b0, cin1 = 1'b0;
    logic       add_min0 = 1'b0, add_min1 = 1'b0;
    logic       symbol0 = 1'b0, symbol1 = 1'b0;
    logic       gnt0, gnt1, done0, done1;
    logic [3:0] dp_a, dp_b;
    logic       dp_cin, dp_add_min, dp_symbol, dp_start;
    logic [3:0] dp_res;
    logic       dp_cout, dp_overflow;
    logic       dp_flag_end = 1'b0;
    logic [3:0] res;
    logic       res_cout, res_ovf, res_err, res_src, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int model_last = 1;
    int dp_lat = 0;      // extra WAIT cycles before flag_end; negative = never
    int dp_cnt = 0;
    bit dp_run = 1'b0;

    add_sub_sched #(.N(3), .TMO(15)) dut (
        .CLK_in(CLK_in), .rst(rst),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .cin0(cin0), .cin1(cin1),
        .add_min0(add_min0), .add_min1(add_min1),
        .symbol0(symbol0), .symbol1(symbol1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .dp_a(dp_a), .dp_b(dp_b), .dp_cin(dp_cin), .dp_add_min(dp_add_min),
        .dp_symbol(dp_symbol), .dp_start(dp_start),
        .dp_res(dp_res), .dp_cout(dp_cout), .dp_overflow(dp_overflow),
        .dp_flag_end(dp_flag_end),
        .res(res), .res_cout(res_cout), .res_ovf(res_ovf), .res_err(res_err),
        .res_src(res_src), .busy(busy)
    );

    always #5 CLK_in = ~CLK_in;

    wire logic [24:0] all_out = {gnt0, gnt1, done0, done1, dp_a, dp_b, dp_cin,
                                 dp_add_min, dp_symbol, dp_start, res, res_cout,
                                 res_ovf, res_err, res_src, busy};
    wire logic [7:0]  res_pack = {res_ovf, res_cout, res, res_err, res_src};

    // Datapath stub arithmetic: 5-bit add/sub with sign-bit overflow rule.
    function automatic logic [5:0] dp_stub(input logic [3:0] a, input logic [3:0] b,
                                           input logic c, input logic am, input logic sym);
        logic [4:0] t;
        logic       o;
        t = am ? ({1'b0, a} + {1'b0, b} + {4'd0, c}) : ({1'b0, a} - {1'b0, b} - {4'd0, c});
        if (!sym)    o = t[4];
        else if (am) o = (a[3] == b[3]) && (t[3] != a[3]);
        else         o = (a[3] != b[3]) && (t[3] != a[3]);
        return {o, t[4], t[3:0]};
    endfunction

    assign {dp_overflow, dp_cout, dp_res} = dp_stub(dp_a, dp_b, dp_cin, dp_add_min, dp_symbol);

    // Reference arithmetic on plain integers: returns {ovf, cout, res}.
    function automatic logic [5:0] exp_result(input logic [3:0] a, input logic [3:0] b,
                                              input logic c, input logic am, input logic sym);
        int ua, ub, sa, sb, ci, u, s;
        logic co, ov;
        ua = int'(a); ub = int'(b); ci = c ? 1 : 0;
        sa = a[3] ? ua - 16 : ua;
        sb = b[3] ? ub - 16 : ub;
        u  = am ? ua + ub + ci : ua - ub - ci;
        s  = am ? sa + sb + ci : sa - sb - ci;
        co = am ? (u > 15) : (u < 0);
        ov = sym ? (s > 7 || s < -8) : co;
        return {ov, co, 4'(u)};
    endfunction

    // Datapath stub handshake: flag_end for one cycle, dp_lat+1 edges after start.
    always @(posedge CLK_in) begin
        #1;
        if (!rst) begin
            dp_run = 1'b0;
            dp_cnt = 0;
        end else if (dp_start) begin
            dp_run = 1'b1;
            dp_cnt = 0;
        end else if (dp_run) begin
            dp_cnt++;
        end
        dp_flag_end = dp_run && (dp_lat >= 0) && (dp_cnt == dp_lat + 1);
        if (dp_flag_end) dp_run = 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK_in);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
        rst = 1'b1;
        model_last = 1;
    endtask

    // Runs one operation: records grant/done cycle and who, dp_* at grant and stability.
    task automatic observe_op(input int budget, input bit hold, input bit scramble,
                              output int g_at, output int g_who, output int d_at, output int d_who,
                              output logic [3:0] s_a, output logic [3:0] s_b,
                              output logic s_cin, output logic s_am, output logic s_sym,
                              output bit stable_ok);
        g_at = -1; g_who = -1; d_at = -1; d_who = -1; stable_ok = 1'b1;
        s_a = 4'd0; s_b = 4'd0; s_cin = 1'b0; s_am = 1'b0; s_sym = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (g_at < 0 && (gnt0 || gnt1)) begin
                g_at = c; g_who = gnt1 ? 1 : 0;
                s_a = dp_a; s_b = dp_b; s_cin = dp_cin; s_am = dp_add_min; s_sym = dp_symbol;
                if (!hold) begin req0 = 1'b0; req1 = 1'b0; end
                if (scramble) begin
                    a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
                    cin0 = 1'($urandom); cin1 = 1'($urandom);
                    add_min0 = 1'($urandom); add_min1 = 1'($urandom);
                end
            end else if (g_at >= 0 &&
                         {dp_a, dp_b, dp_cin, dp_add_min, dp_symbol} !== {s_a, s_b, s_cin, s_am, s_sym}) begin
                stable_ok = 1'b0;
            end
            if (done0 || done1) begin
                d_at = c; d_who = done1 ? 1 : 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        n_tests++;
        if (all_out !== 25'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
        rst = 1'b1;
        tick(); tick(); tick();
        n_tests++;
        if (all_out !== 25'd0) begin n_fail++; $display("FAIL idle_no_req: got %h expected 0", all_out); end
        model_last = 1;
    endtask

    task automatic test_single_add();
        int g_at, g_who, d_at, d_who; logic [3:0] sa, sb; logic sc, sam, ss; bit st;
        tick(); tick();
        dp_lat = 0;
        a0 = 4'b0101; b0 = 4'b0011; cin0 = 1'b0; add_min0 = 1'b1; symbol0 = 1'b0;
        req0 = 1'b1; req1 = 1'b0;
        observe_op(40, 1'b0, 1'b1, g_at, g_who, d_at, d_who, sa, sb, sc, sam, ss, st);
        model_last = 0;
        n_tests++;
        if (g_at !== 1 || g_who !== 0) begin n_fail++; $display("FAIL add_grant: got at=%0d who=%0d expected at=1 who=0", g_at, g_who); end
        n_tests++;
        if (d_at !== 3 || d_who !== 0) begin n_fail++; $display("FAIL add_done: got at=%0d who=%0d expected at=3 who=0", d_at, d_who); end
        n_tests++;
        if (res !== 4'b1000 || res_cout !== 1'b0 || res_src !== 1'b0 || res_err !== 1'b0) begin
            n_fail++; $display("FAIL add_result: got %h expected res=8 cout=0 src=0 err=0", res_pack);
        end
        n_tests++;
        if (!st) begin n_fail++; $display("FAIL add_dp_stable: got unstable expected stable"); end
    endtask

    task automatic test_signed_sub();
        int g_at, g_who, d_at, d_who; logic [3:0] sa, sb; logic sc, sam, ss; bit st;
        tick(); tick();
        dp_lat = 2;
        a1 = 4'b0111; b1 = 4'b1000; cin1 = 1'b0; add_min1 = 1'b0; symbol1 = 1'b1;
        req0 = 1'b0; req1 = 1'b1;
        observe_op(40, 1'b0, 1'b1, g_at, g_who, d_at, d_who, sa, sb, sc, sam, ss, st);
        model_last = 1;
        n_tests++;
        if (g_who !== 1 || d_who !== 1 || d_at - g_at !== 4) begin
            n_fail++; $display("FAIL sub_handshake: got g=%0d d=%0d lat=%0d expected 1 1 4", g_who, d_who, d_at - g_at);
        end
        n_tests++;
        if (res !== 4'b1111 || res_ovf !== 1'b1 || res_src !== 1'b1 || res_err !== 1'b0) begin
            n_fail++; $display("FAIL sub_result: got %h expected res=f ovf=1 src=1 err=0", res_pack);
        end
        n_tests++;
        if (sam !== 1'b0 || ss !== 1'b1 || !st) begin
            n_fail++; $display("FAIL sub_dp_ctrl: got add_min=%0b symbol=%0b stable=%0b expected 0 1 1", sam, ss, st);
        end
    endtask

    task automatic test_contention();
        int g_at, g_who, d_at, d_who, span, ew; logic [3:0] sa, sb; logic sc, sam, ss; bit st;
        logic [5:0] e;
        apply_reset();
        dp_lat = 0;
        a0 = 4'($urandom); b0 = 4'($urandom); cin0 = 1'($urandom); add_min0 = 1'($urandom); symbol0 = 1'($urandom);
        a1 = 4'($urandom); b1 = 4'($urandom); cin1 = 1'($urandom); add_min1 = 1'($urandom); symbol1 = 1'($urandom);
        req0 = 1'b1; req1 = 1'b1;
        span = 0;
        for (int i = 0; i < 3; i++) begin
            ew = 1 - model_last;
            model_last = ew;
            e = (ew == 1) ? exp_result(a1, b1, cin1, add_min1, symbol1) : exp_result(a0, b0, cin0, add_min0, symbol0);
            observe_op(40, 1'b1, 1'b0, g_at, g_who, d_at, d_who, sa, sb, sc, sam, ss, st);
            n_tests++;
            if (g_who !== ew) begin n_fail++; $display("FAIL rr_order%0d: got %0d expected %0d", i, g_who, ew); end
            n_tests++;
            if ((i == 0 && g_at !== 1) || (i > 0 && span + g_at < 4)) begin
                n_fail++; $display("FAIL rr_spacing%0d: got %0d expected >=4", i, span + g_at);
            end
            n_tests++;
            if (res_pack !== {e[5], e[4], e[3:0], 1'b0, 1'(ew)} || !st) begin
                n_fail++; $display("FAIL rr_result%0d: got %h stable=%0b expected %h stable=1", i, res_pack, st, {e[5], e[4], e[3:0], 1'b0, 1'(ew)});
            end
            span = d_at - g_at;
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
    endtask

    task automatic test_timeout();
        int g_at, g_who, d_at, d_who; logic [3:0] sa, sb; logic sc, sam, ss; bit st;
        tick(); tick();
        dp_lat = -1;
        a0 = 4'($urandom); b0 = 4'($urandom); add_min0 = 1'b1;
        req0 = 1'b1; req1 = 1'b0;
        observe_op(40, 1'b0, 1'b0, g_at, g_who, d_at, d_who, sa, sb, sc, sam, ss, st);
        model_last = 0;
        n_tests++;
        if (g_at !== 1 || d_at !== 17 || d_who !== 0) begin
            n_fail++; $display("FAIL tmo_latency: got g=%0d d=%0d who=%0d expected 1 17 0", g_at, d_at, d_who);
        end
        n_tests++;
        if (res_pack !== 8'b0000_0010) begin n_fail++; $display("FAIL tmo_result: got %h expected 02", res_pack); end
        tick();
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_coincidence();
        int g_at, g_who, d_at, d_who; logic [3:0] sa, sb; logic sc, sam, ss; bit st;
        logic [5:0] e;
        tick(); tick();
        dp_lat = 14;
        a1 = 4'($urandom); b1 = 4'($urandom); cin1 = 1'($urandom); add_min1 = 1'($urandom); symbol1 = 1'($urandom);
        e = exp_result(a1, b1, cin1, add_min1, symbol1);
        req0 = 1'b0; req1 = 1'b1;
        observe_op(40, 1'b0, 1'b1, g_at, g_who, d_at, d_who, sa, sb, sc, sam, ss, st);
        model_last = 1;
        n_tests++;
        if (d_at - g_at !== 16 || d_who !== 1) begin
            n_fail++; $display("FAIL coin_latency: got %0d who=%0d expected 16 who=1", d_at - g_at, d_who);
        end
        n_tests++;
        if (res_pack !== {e[5], e[4], e[3:0], 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL coin_result: got %h expected %h", res_pack, {e[5], e[4], e[3:0], 1'b0, 1'b1});
        end
    endtask

    task automatic test_reset_mid_wait();
        int g_at, g_who, d_at, d_who; logic [3:0] sa, sb; logic sc, sam, ss; bit st, seen, done_seen;
        tick(); tick();
        dp_lat = -1;
        a0 = 4'($urandom); b0 = 4'($urandom);
        req0 = 1'b1; req1 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            tick();
            seen = gnt0;
        end
        req0 = 1'b0;
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL rstw_grant: got none expected gnt0"); end
        tick(); tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if (all_out !== 25'd0) begin n_fail++; $display("FAIL rstw_outputs: got %h expected 0", all_out); end
        done_seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done0 || done1) done_seen = 1'b1;
        end
        n_tests++;
        if (done_seen) begin n_fail++; $display("FAIL rstw_no_done: got done expected none"); end
        dp_lat = 0;
        req1 = 1'b1;
        rst = 1'b1;
        model_last = 1;
        observe_op(40, 1'b0, 1'b1, g_at, g_who, d_at, d_who, sa, sb, sc, sam, ss, st);
        n_tests++;
        if (g_who !== 1 || d_who !== 1 || res_src !== 1'b1) begin
            n_fail++; $display("FAIL rstw_after: got g=%0d d=%0d src=%0b expected 1 1 1", g_who, d_who, res_src);
        end
    endtask

    task automatic test_random();
        int lat_tab[7] = '{0, 1, 2, 3, 14, 15, -1};
        int g_at, g_who, d_at, d_who, ew, r, lat; logic [3:0] sa, sb; logic sc, sam, ss; bit st, tmo;
        logic [5:0] e; logic [7:0] ep;
        for (int i = 0; i < 24; i++) begin
            a0 = 4'($urandom); b0 = 4'($urandom); cin0 = 1'($urandom); add_min0 = 1'($urandom); symbol0 = 1'($urandom);
            a1 = 4'($urandom); b1 = 4'($urandom); cin1 = 1'($urandom); add_min1 = 1'($urandom); symbol1 = 1'($urandom);
            lat = lat_tab[$urandom_range(0, 6)];
            dp_lat = lat;
            r = int'($urandom_range(1, 3));
            ew = (r == 3) ? 1 - model_last : (r == 2 ? 1 : 0);
            model_last = ew;
            e = (ew == 1) ? exp_result(a1, b1, cin1, add_min1, symbol1) : exp_result(a0, b0, cin0, add_min0, symbol0);
            tmo = (lat < 0) || (lat + 1 > 15);
            ep = tmo ? {7'b0000001, 1'(ew)} : {e[5], e[4], e[3:0], 1'b0, 1'(ew)};
            req0 = 1'(r & 1); req1 = 1'(r >> 1);
            observe_op(40, 1'b0, 1'b1, g_at, g_who, d_at, d_who, sa, sb, sc, sam, ss, st);
            n_tests++;
            if (g_who !== ew || d_who !== ew) begin
                n_fail++; $display("FAIL rnd_winner%0d: got g=%0d d=%0d expected %0d", i, g_who, d_who, ew);
            end
            n_tests++;
            if (d_at - g_at !== (tmo ? 16 : lat + 2)) begin
                n_fail++; $display("FAIL rnd_latency%0d: got %0d expected %0d", i, d_at - g_at, tmo ? 16 : lat + 2);
            end
            n_tests++;
            if (res_pack !== ep || !st) begin
                n_fail++; $display("FAIL rnd_result%0d: got %h stable=%0b expected %h stable=1", i, res_pack, st, ep);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_signed_sub();
        test_contention();
        test_timeout();
        test_coincidence();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
